// File: rtl/ad7946_avg.sv
// ad7946_avg: per-channel boxcar averager and 2^LOG2N decimator for the
// AD7946 controller sample stream. Completed averages wait in one pending
// register per channel, are arbitrated (channel 0 first) into a small
// first-word-fall-through FIFO and leave on a valid/ready stream with a
// channel tag. Results that find their pending register still occupied
// are dropped and flagged on the sticky ovf output.
module ad7946_avg #(
    parameter int DW         = 14,
    parameter int LOG2N      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          ch0_dv,
    input  logic          ch1_dv,
    input  logic [DW-1:0] din,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_chan,
    output logic [DW-1:0] m_data,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int AW = DW + LOG2N;
    localparam int CW = (LOG2N > 0) ? LOG2N : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DW + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((1 << LOG2N) - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    // Per-channel state (index 0 = channel 0, index 1 = channel 1)
    logic [AW-1:0] acc_q  [2];
    logic [AW-1:0] acc_d  [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic [DW-1:0] pval_q [2];
    logic [DW-1:0] pval_d [2];
    logic [1:0]    pend_q;
    logic [1:0]    pend_d;
    logic          ovf_q;
    logic          ovf_d;

    // Output FIFO: entries are {chan, data}; pointers carry one wrap bit
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]   wr_q;
    logic [PW:0]   wr_d;
    logic [PW:0]   rd_q;
    logic [PW:0]   rd_d;

    logic [1:0]    dv_s;
    logic [AW-1:0] sum_s [2];
    logic [DW-1:0] res_s [2];
    logic [1:0]    complete_s;
    logic [1:0]    drop_s;
    logic [1:0]    drain_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          can_wr_s;
    logic          push_s;
    logic [EW-1:0] push_word_s;

    // FIFO status, arbitration, averaging datapath and next-state logic
    always_comb begin
        dv_s     = {ch1_dv, ch0_dv};
        empty_s  = (wr_q == rd_q);
        full_s   = ((wr_q - rd_q) == FIFO_FULL);
        pop_s    = !empty_s && m_ready;
        // A slot freed by a pop in the same cycle may be refilled at once
        can_wr_s = !full_s || pop_s;

        drain_s[0] = pend_q[0] && can_wr_s;
        drain_s[1] = pend_q[1] && can_wr_s && !pend_q[0];
        push_s     = drain_s[0] || drain_s[1];
        if (drain_s[0]) begin
            push_word_s = {1'b0, pval_q[0]};
        end else begin
            push_word_s = {1'b1, pval_q[1]};
        end

        wr_d = wr_q + (PW + 1)'(push_s);
        rd_d = rd_q + (PW + 1)'(pop_s);

        for (int c = 0; c < 2; c++) begin
            sum_s[c]      = acc_q[c] + AW'(din);
            // Truncating average: the low LOG2N bits are discarded
            res_s[c]      = DW'(sum_s[c] >> LOG2N);
            complete_s[c] = enable && dv_s[c] && (cnt_q[c] == CNT_LAST);
            // Drain-then-reload in one cycle is not a drop
            drop_s[c]     = complete_s[c] && pend_q[c] && !drain_s[c];

            acc_d[c]  = acc_q[c];
            cnt_d[c]  = cnt_q[c];
            pend_d[c] = pend_q[c];
            pval_d[c] = pval_q[c];

            if (!enable) begin
                acc_d[c] = {AW{1'b0}};
                cnt_d[c] = {CW{1'b0}};
            end else if (complete_s[c]) begin
                acc_d[c] = {AW{1'b0}};
                cnt_d[c] = {CW{1'b0}};
            end else if (dv_s[c]) begin
                acc_d[c] = sum_s[c];
                cnt_d[c] = cnt_q[c] + CW'(1);
            end else begin
                acc_d[c] = acc_q[c];
                cnt_d[c] = cnt_q[c];
            end

            if (complete_s[c] && !drop_s[c]) begin
                pend_d[c] = 1'b1;
                pval_d[c] = res_s[c];
            end else if (drain_s[c]) begin
                pend_d[c] = 1'b0;
            end else begin
                pend_d[c] = pend_q[c];
            end
        end

        // A drop in the same cycle as a clear leaves the flag set
        if (drop_s != 2'b00) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                acc_q[c]  <= {AW{1'b0}};
                cnt_q[c]  <= {CW{1'b0}};
                pval_q[c] <= {DW{1'b0}};
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
            pend_q <= 2'b00;
            ovf_q  <= 1'b0;
            wr_q   <= {(PW + 1){1'b0}};
            rd_q   <= {(PW + 1){1'b0}};
        end else begin
            for (int c = 0; c < 2; c++) begin
                acc_q[c]  <= acc_d[c];
                cnt_q[c]  <= cnt_d[c];
                pval_q[c] <= pval_d[c];
            end
            if (push_s) begin
                mem_q[wr_q[PW-1:0]] <= push_word_s;
            end
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    // Output view of the FIFO head; tag and data read as zero when empty
    always_comb begin
        m_valid = !empty_s;
        ovf     = ovf_q;
        if (empty_s) begin
            m_chan = 1'b0;
            m_data = {DW{1'b0}};
        end else begin
            m_chan = mem_q[rd_q[PW-1:0]][DW];
            m_data = mem_q[rd_q[PW-1:0]][DW-1:0];
        end
    end

endmodule

// File: tb/tb_ad7946_avg.sv
// Bench for ad7946_avg: instance A uses LOG2N=2, instance B uses LOG2N=0.
// A queue-based reference model predicts the outputs every cycle; directed
// sequences add hand-computed expectations.
module tb_ad7946_avg;
    localparam int DW    = 14;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst, en, d0, d1, rdy, clr;
    logic [DW-1:0] din [2];
    wire           a_mv, a_mc, a_ov, b_mv, b_mc, b_ov;
    wire [DW-1:0]  a_md, b_md;

    ad7946_avg #(.DW(DW), .LOG2N(2), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .ch0_dv(d0[0]), .ch1_dv(d1[0]),
        .din(din[0]), .m_valid(a_mv), .m_ready(rdy[0]), .m_chan(a_mc),
        .m_data(a_md), .ovf(a_ov), .ovf_clr(clr[0]));

    ad7946_avg #(.DW(DW), .LOG2N(0), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .ch0_dv(d0[1]), .ch1_dv(d1[1]),
        .din(din[1]), .m_valid(b_mv), .m_ready(rdy[1]), .m_chan(b_mc),
        .m_data(b_md), .ovf(b_ov), .ovf_clr(clr[1]));

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance k and channel c
    int sum  [2][2];
    int cnt  [2][2];
    int pval [2][2];
    bit pend [2][2];
    int fq   [2][$];
    bit eovf [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic g_mv(input int k);
        return (k == 0) ? a_mv : b_mv;
    endfunction
    function automatic logic g_mc(input int k);
        return (k == 0) ? a_mc : b_mc;
    endfunction
    function automatic logic [DW-1:0] g_md(input int k);
        return (k == 0) ? a_md : b_md;
    endfunction
    function automatic logic g_ov(input int k);
        return (k == 0) ? a_ov : b_ov;
    endfunction

    // One clock of the model, using the inputs sampled at this edge
    task automatic step(input int k);
        int lg, n, res;
        bit pop, canw, dr0, dr1, drop, dv;
        lg = (k == 0) ? 2 : 0;
        n  = 1 << lg;
        if (rst[k]) begin
            for (int c = 0; c < 2; c++) begin
                sum[k][c] = 0; cnt[k][c] = 0; pend[k][c] = 0; pval[k][c] = 0;
            end
            fq[k].delete();
            eovf[k] = 0;
            return;
        end
        pop  = (fq[k].size() > 0) && rdy[k];
        canw = (fq[k].size() < DEPTH) || pop;
        dr0  = pend[k][0] && canw;
        dr1  = pend[k][1] && canw && !pend[k][0];
        if (pop) void'(fq[k].pop_front());
        if (dr0) begin
            fq[k].push_back(pval[k][0]);
            pend[k][0] = 0;
        end else if (dr1) begin
            fq[k].push_back(65536 + pval[k][1]);
            pend[k][1] = 0;
        end
        drop = 0;
        for (int c = 0; c < 2; c++) begin
            dv = (c == 0) ? d0[k] : d1[k];
            if (en[k] && dv) begin
                if (cnt[k][c] == n - 1) begin
                    res = (sum[k][c] + int'(din[k])) >> lg;
                    sum[k][c] = 0; cnt[k][c] = 0;
                    if (pend[k][c]) drop = 1;
                    else begin pend[k][c] = 1; pval[k][c] = res; end
                end else begin
                    sum[k][c] += int'(din[k]);
                    cnt[k][c]++;
                end
            end
            if (!en[k]) begin sum[k][c] = 0; cnt[k][c] = 0; end
        end
        if (drop) eovf[k] = 1;
        else if (clr[k]) eovf[k] = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            step(0);
            step(1);
        end
    end

    // Every-cycle comparison of both instances against the model
    task automatic cmp(input int k);
        bit ev; int ec, ed;
        ev = fq[k].size() > 0;
        ec = ev ? (fq[k][0] >> 16) : 0;
        ed = ev ? (fq[k][0] & 16'hFFFF) : 0;
        check($sformatf("model_valid[%0d]", k), 32'(g_mv(k)), 32'(ev));
        check($sformatf("model_chan[%0d]", k), 32'(g_mc(k)), 32'(ec));
        check($sformatf("model_data[%0d]", k), 32'(g_md(k)), 32'(ed));
        check($sformatf("model_ovf[%0d]", k), 32'(g_ov(k)), 32'(eovf[k]));
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cmp(0);
            cmp(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int k, input bit c0, input bit c1, input int v);
        d0[k] = c0; d1[k] = c1; din[k] = DW'(v);
        tick();
        d0[k] = 1'b0; d1[k] = 1'b0;
    endtask

    // Wait (bounded) for the next output word and check it; returns just
    // after the following clock edge
    task automatic wait_word(input int k, input int ec, input int ed, input string nm);
        int i;
        i = 0;
        @(negedge clk);
        while (!g_mv(k) && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({nm, "_valid"}, 32'(g_mv(k)), 32'd1);
        check({nm, "_chan"}, 32'(g_mc(k)), 32'(ec));
        check({nm, "_data"}, 32'(g_md(k)), 32'(ed));
        tick();
    endtask

    initial begin
        rst = 2'b11; en = 2'b11; d0 = 2'b00; d1 = 2'b00; rdy = 2'b01; clr = 2'b00;
        din[0] = '0; din[1] = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_valid", 32'(a_mv), 32'd0);
        check("reset_data", 32'(a_md), 32'd0);
        check("reset_chan", 32'(a_mc), 32'd0);
        check("reset_ovf", 32'(b_ov), 32'd0);
        tick();
        rst = 2'b00;
        tick();

        // Average of 100..103 and its two-cycle latency
        for (int v = 100; v < 104; v++) smp(0, 1'b1, 1'b0, v);
        @(negedge clk);
        check("lat_t1_valid", 32'(a_mv), 32'd0);
        tick();
        @(negedge clk);
        check("lat_t2_valid", 32'(a_mv), 32'd1);
        check("avg101_chan", 32'(a_mc), 32'd0);
        check("avg101_data", 32'(a_md), 32'd101);
        tick();
        repeat (3) tick();

        // Full-scale ch1 samples do not wrap; small sums truncate
        repeat (4) smp(0, 1'b0, 1'b1, 16383);
        wait_word(0, 1, 16383, "fullscale");
        smp(0, 1'b0, 1'b1, 3);
        repeat (3) smp(0, 1'b0, 1'b1, 0);
        wait_word(0, 1, 0, "trunc");

        // Interleaved channels, simultaneous final strobe (shared din=10)
        smp(0, 1'b1, 1'b0, 10);  smp(0, 1'b0, 1'b1, 2664);
        smp(0, 1'b1, 1'b0, 10);  smp(0, 1'b0, 1'b1, 2663);
        smp(0, 1'b1, 1'b0, 10);  smp(0, 1'b0, 1'b1, 2663);
        smp(0, 1'b1, 1'b1, 10);
        wait_word(0, 0, 10, "simul_ch0");
        @(negedge clk);
        check("simul_ch1_valid", 32'(a_mv), 32'd1);
        check("simul_ch1_chan", 32'(a_mc), 32'd1);
        check("simul_ch1_data", 32'(a_md), 32'd2000);
        tick();

        // LOG2N=0 back-pressure: FIFO 1..4, pending 5, 6 and 7 dropped
        for (int v = 1; v < 8; v++) smp(1, 1'b1, 1'b0, v);
        repeat (2) tick();
        @(negedge clk);
        check("bp_ovf", 32'(b_ov), 32'd1);
        check("bp_head", 32'(b_md), 32'd1);
        tick();
        rdy[1] = 1'b1;
        for (int v = 1; v < 6; v++) wait_word(1, 0, v, $sformatf("bp_out%0d", v));
        repeat (2) tick();
        @(negedge clk);
        check("bp_drained", 32'(b_mv), 32'd0);
        tick();
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(b_ov), 32'd0);
        tick();

        // Reset mid-accumulation discards the partial sum
        repeat (2) smp(0, 1'b1, 1'b0, 50);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        repeat (4) smp(0, 1'b1, 1'b0, 8);
        wait_word(0, 0, 8, "rst_flush");
        repeat (4) tick();
        @(negedge clk);
        check("rst_single", 32'(a_mv), 32'd0);
        tick();

        // Enable pulsed low does the same
        repeat (2) smp(0, 1'b1, 1'b0, 50);
        en[0] = 1'b0; tick(); en[0] = 1'b1;
        repeat (4) smp(0, 1'b1, 1'b0, 8);
        wait_word(0, 0, 8, "en_flush");
        repeat (4) tick();

        // Randomized traffic on both instances, checked by the model
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 199) == 0);
                en[k]  = ($urandom_range(0, 19) != 0);
                d0[k]  = ($urandom_range(0, 2) == 0);
                d1[k]  = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 3))
                    0:       din[k] = '0;
                    1:       din[k] = '1;
                    default: din[k] = DW'($urandom);
                endcase
                rdy[k] = ($urandom_range(0, 1) == 1);
                clr[k] = ($urandom_range(0, 29) == 0);
            end
            tick();
        end
        rst = 2'b00; en = 2'b11; d0 = 2'b00; d1 = 2'b00; rdy = 2'b11; clr = 2'b00;
        repeat (12) tick();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
